lsp_cb5_dequant: RTL and testbench

//  Decoder-side counterpart of the LSP codebook-5 search: accepts a 4-bit cb5 index
//  and returns the dequantised LSP. Output is either the codebook frequency (Hz) or

---
 rtl/lsp_cb5_dequant.sv | 98 +++++++++
 tb/tb_lsp_cb5_dequant.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsp_cb5_dequant.sv
// LSP codebook-5 dequantiser: cb5 index -> 1-15-16 LSP in Hz or radians.
// Three-stage pipeline; a downstream stall freezes every stage together.
module lsp_cb5_dequant #(
  parameter int          N     = 32,
  parameter logic [31:0] K_Q32 = 32'd3373259,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_index,
  input  logic             in_last,
  input  logic             rad_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] dec_count
);

  logic         stall;
  logic         v1;
  logic         m1;
  logic         l1;
  logic [N-1:0] d1;
  logic         v2;
  logic         l2;
  logic [N-1:0] d2;
  logic [N-1:0] tbl;
  logic [N-1:0] scaled;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // (1100 + 100*i) Hz in 1-15-16 format
  always_comb begin
    tbl = '0;
    unique case (in_index)
      4'd0:  tbl = 32'h044C_0000;
      4'd1:  tbl = 32'h04B0_0000;
      4'd2:  tbl = 32'h0514_0000;
      4'd3:  tbl = 32'h0578_0000;
      4'd4:  tbl = 32'h05DC_0000;
      4'd5:  tbl = 32'h0640_0000;
      4'd6:  tbl = 32'h06A4_0000;
      4'd7:  tbl = 32'h0708_0000;
      4'd8:  tbl = 32'h076C_0000;
      4'd9:  tbl = 32'h07D0_0000;
      4'd10: tbl = 32'h0834_0000;
      4'd11: tbl = 32'h0898_0000;
      4'd12: tbl = 32'h08FC_0000;
      4'd13: tbl = 32'h0960_0000;
      4'd14: tbl = 32'h09C4_0000;
      4'd15: tbl = 32'h0A28_0000;
    endcase
  end

  // Hz -> rad: keep the upper word of the unsigned Q0.32 product
  assign scaled = N'((64'(d1) * 64'(K_Q32)) >> 32);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      m1        <= 1'b0;
      l1        <= 1'b0;
      d1        <= '0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      d2        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= tbl;
        m1 <= rad_mode;
        l1 <= in_last;
      end
      v2        <= v1;
      d2        <= m1 ? scaled : d1;
      l2        <= l1;
      out_valid <= v2;
      out_data  <= d2;
      out_last  <= l2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_count <= '0;
    end else if (out_valid && out_ready && !(&dec_count)) begin
      dec_count <= dec_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lsp_cb5_dequant.sv
// Bench for lsp_cb5_dequant: vector table, directed sequences and a
// randomized stream checked against an arithmetic reference model.
module tb_lsp_cb5_dequant;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_index;
  logic        in_last;
  logic        rad_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] dec_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic        s_out_last;
  logic [1:0]  s_dec_count;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  lsp_cb5_dequant dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_last(in_last),
    .rad_mode(rad_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .dec_count(dec_count)
  );

  lsp_cb5_dequant #(.CNT_W(2)) sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_index(in_index), .in_last(in_last),
    .rad_mode(rad_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_last(s_out_last),
    .dec_count(s_dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // frequency from the table rule, optionally scaled by 2*pi/8000 in Q0.32
  function automatic logic [31:0] ref_val(input logic [3:0] idx,
                                          input logic rad);
    longint unsigned hz;
    longint unsigned fx;
    hz = 64'd1100 + 64'd100 * 64'(idx);
    fx = hz << 16;
    if (rad) fx = (fx * 64'd3373259) >> 32;
    return fx[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] idx, input logic rad,
                     input logic last);
    in_valid = 1'b1;
    in_index = idx;
    rad_mode = rad;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // scoreboard / protocol monitor, sampling mid-cycle
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        hs_count   = 0;
      end else begin
        check("in_ready", 32'(in_ready),
              32'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", out_data, prev_data);
          check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (in_valid && in_ready)
          exp_q.push_back({in_last, ref_val(in_index, rad_mode)});
        if (out_valid && out_ready) begin
          hs_count++;
          got_q.push_back({out_last, out_data});
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_beat got=%h exp=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", out_data, e[31:0]);
            check("sb_last", 32'(out_last), 32'(e[32]));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  idx;
    logic        rad;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   acc;
    int   cyc;

    vecs[0] = '{4'd0,  1'b0, 32'h044C_0000};
    vecs[1] = '{4'd15, 1'b0, 32'h0A28_0000};
    vecs[2] = '{4'd5,  1'b0, 32'h0640_0000};
    vecs[3] = '{4'd0,  1'b1, 32'h0000_DD2B};
    vecs[4] = '{4'd15, 1'b1, 32'h0002_0AC2};
    vecs[5] = '{4'd8,  1'b1, 32'h0001_7E04};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_index  = '0;
    in_last   = 1'b0;
    rad_mode  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_count", 32'(dec_count), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single beat latency
    put(4'd0, 1'b0, 1'b0);
    tick();
    check("lat_early", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'h044C_0000);
    tick();
    check("lat_count", 32'(dec_count), 32'd1);

    for (int i = 0; i < 6; i++) begin
      put(vecs[i].idx, vecs[i].rad, 1'b0);
      tick();
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      tick();
    end

    // 16 back-to-back radians beats
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_index = 4'(i);
      rad_mode = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("burst_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      check("burst_first", got_q[0][31:0], 32'h0000_DD2B);
      check("burst_last", got_q[15][31:0], 32'h0002_0AC2);
    end

    // random stream with random backpressure
    got_q.delete();
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = 4'($urandom_range(0, 15));
      rad_mode  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_accepted", 32'(acc), 32'd8);
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(got_q.size()), 32'd8);

    // frame of ten with in_last on the tenth
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_index = 4'($urandom_range(0, 15));
      rad_mode = 1'($urandom_range(0, 1));
      in_last  = (i == 9);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (4) tick();
    check("frame_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("frame_last%0d", i), 32'(got_q[i][32]),
            32'(i == 9));

    // async reset with three beats in flight
    got_q.delete();
    out_ready = 1'b0;
    put(4'd1, 1'b0, 1'b0);
    put(4'd2, 1'b1, 1'b0);
    put(4'd3, 1'b0, 1'b1);
    check("flight_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_drop", 32'(out_valid), 32'd0);
    check("async_count", 32'(dec_count), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_count", 32'(dec_count), 32'd0);
    put(4'd3, 1'b1, 1'b0);
    repeat (3) tick();
    check("post_rst_beats", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1)
      check("post_rst_data", got_q[0][31:0], ref_val(4'd3, 1'b1));
    check("sat_one", 32'(s_dec_count), 32'd1);

    // counter saturation on the narrow-counter instance
    for (int i = 0; i < 4; i++) put(4'(i + 6), 1'b0, 1'b0);
    repeat (3) tick();
    check("hs_total", 32'(hs_count), 32'd5);
    check("main_count", 32'(dec_count), 32'(hs_count));
    check("sat_hold", 32'(s_dec_count), 32'd3);
    put(4'd9, 1'b1, 1'b0);
    repeat (3) tick();
    check("sat_still", 32'(s_dec_count), 32'd3);
    check("main_count2", 32'(dec_count), 32'(hs_count));
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
